// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-timer datapath: FSM state encoding,
// LFSR constants and the default timing values used by the sibling blocks.
package reaction_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_MEASURE = 3'd2,
    ST_CONVERT = 3'd3,
    ST_SHOW    = 3'd4,
    ST_CHEAT   = 3'd5
  } state_e;

  // 16-bit Galois LFSR, x^16 + x^14 + x^13 + x^11, right-shifting form.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int MS_DIV_DEFAULT     = 50000;
  localparam int TIMEOUT_MS_DEFAULT = 1000;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/reaction_test_ctrl_ms_tick_gen.sv
// Millisecond prescaler: counts 0..DIV-1 and flags the last count; a
// synchronous clear restarts the count so the next ms is full length.
module ms_tick_gen
  import reaction_pkg::*;
#(
  parameter int DIV = MS_DIV_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/reaction_test_ctrl.sv
// Reaction-timer trial sequencer: random wait, LED, ms measurement, BCD handoff.
// Optional `define BEST_TIME_EN adds a best_ms output tracking the fastest valid trial.
module reaction_test_ctrl
  import reaction_pkg::*;
#(
  parameter int MS_DIV         = MS_DIV_DEFAULT,
  parameter int MIN_WAIT_MS    = 2000,
  parameter int WAIT_RAND_BITS = 12,
  parameter int TIMEOUT_MS     = TIMEOUT_MS_DEFAULT,
  parameter int BIN_W          = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             clear,
  output logic             led,
  output logic [BIN_W-1:0] bin,
  output logic             conv_start,
  input  logic             conv_done,
  output logic             result_valid,
  output logic             cheat,
  output logic             timeout,
  output logic [2:0]       state
`ifdef BEST_TIME_EN
  ,
  output logic [BIN_W-1:0] best_ms
`endif
);

  localparam int WAIT_MAX = MIN_WAIT_MS + (1 << WAIT_RAND_BITS) - 1;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
  localparam int MS_W     = $clog2(TIMEOUT_MS);

  state_e             state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [WAIT_W-1:0]  wait_target_q, wait_target_d;
  logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [MS_W-1:0]    ms_cnt_q, ms_cnt_d;
  logic               led_q, led_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic               conv_start_q, conv_start_d;
  logic               result_valid_q, result_valid_d;
  logic               cheat_q, cheat_d;
  logic               timeout_q, timeout_d;

  logic               ms_tick;
  logic               tick_clr;

  ms_tick_gen #(
    .DIV (MS_DIV)
  ) u_ms_tick (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .tick  (ms_tick)
  );

  assign lfsr_d = lfsr_step(lfsr_q);

  // Restart the prescaler whenever a timed phase begins.
  assign tick_clr = ((state_d == ST_WAIT)    && (state_q != ST_WAIT)) ||
                    ((state_d == ST_MEASURE) && (state_q != ST_MEASURE));

  always_comb begin
    state_d        = state_q;
    wait_target_d  = wait_target_q;
    wait_cnt_d     = wait_cnt_q;
    ms_cnt_d       = ms_cnt_q;
    led_d          = led_q;
    bin_d          = bin_q;
    conv_start_d   = 1'b0;
    result_valid_d = result_valid_q;
    cheat_d        = cheat_q;
    timeout_d      = timeout_q;

    if (clear) begin
      state_d        = ST_IDLE;
      led_d          = 1'b0;
      result_valid_d = 1'b0;
      cheat_d        = 1'b0;
      timeout_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_SHOW: begin
          if (start && !stop) begin
            state_d        = ST_WAIT;
            wait_target_d  = WAIT_W'(MIN_WAIT_MS) + WAIT_W'(lfsr_q[WAIT_RAND_BITS-1:0]);
            wait_cnt_d     = '0;
            result_valid_d = 1'b0;
            cheat_d        = 1'b0;
            timeout_d      = 1'b0;
          end
        end

        ST_WAIT: begin
          if (stop) begin
            state_d = ST_CHEAT;
            cheat_d = 1'b1;
          end else if (ms_tick) begin
            if (wait_cnt_q == wait_target_q - WAIT_W'(1)) begin
              state_d  = ST_MEASURE;
              ms_cnt_d = '0;
              led_d    = 1'b1;
            end else begin
              wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
          end
        end

        ST_MEASURE: begin
          // A stop coinciding with the final tick reports the count it saw.
          if (stop) begin
            state_d      = ST_CONVERT;
            bin_d        = BIN_W'(ms_cnt_q);
            led_d        = 1'b0;
            conv_start_d = 1'b1;
          end else if (ms_tick) begin
            if (ms_cnt_q == MS_W'(TIMEOUT_MS - 1)) begin
              state_d      = ST_CONVERT;
              bin_d        = BIN_W'(TIMEOUT_MS);
              timeout_d    = 1'b1;
              led_d        = 1'b0;
              conv_start_d = 1'b1;
            end else begin
              ms_cnt_d = ms_cnt_q + MS_W'(1);
            end
          end
        end

        ST_CONVERT: begin
          led_d = 1'b0;
          if (conv_done) begin
            state_d        = ST_SHOW;
            result_valid_d = 1'b1;
          end
        end

        ST_CHEAT: begin
          state_d = ST_CHEAT;
        end

        default: begin
          state_d = ST_IDLE;
          led_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      lfsr_q         <= LFSR_SEED;
      wait_target_q  <= '0;
      wait_cnt_q     <= '0;
      ms_cnt_q       <= '0;
      led_q          <= 1'b0;
      bin_q          <= '0;
      conv_start_q   <= 1'b0;
      result_valid_q <= 1'b0;
      cheat_q        <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lfsr_q         <= lfsr_d;
      wait_target_q  <= wait_target_d;
      wait_cnt_q     <= wait_cnt_d;
      ms_cnt_q       <= ms_cnt_d;
      led_q          <= led_d;
      bin_q          <= bin_d;
      conv_start_q   <= conv_start_d;
      result_valid_q <= result_valid_d;
      cheat_q        <= cheat_d;
      timeout_q      <= timeout_d;
    end
  end

  assign state        = state_q;
  assign led          = led_q;
  assign bin          = bin_q;
  assign conv_start   = conv_start_q;
  assign result_valid = result_valid_q;
  assign cheat        = cheat_q;
  assign timeout      = timeout_q;

`ifdef BEST_TIME_EN
  logic [BIN_W-1:0] best_q, best_d;

  // Survives clear; only reset returns it to the "no result yet" value.
  always_comb begin
    best_d = best_q;
    if ((state_d == ST_SHOW) && (state_q != ST_SHOW) && !timeout_q && (bin_q < best_q)) begin
      best_d = bin_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      best_q <= '1;
    end else begin
      best_q <= best_d;
    end
  end

  assign best_ms = best_q;
`endif

endmodule

// File: doc/reaction_test_ctrl.md
Name: reaction_test_ctrl

Overview:
Sequencing controller for the reaction-timer datapath. Runs one trial: pseudo-random wait, LED on, millisecond measurement, then handoff of the binary result to the external bin-to-BCD converter through a start/done handshake. Detects early presses ("cheat") and no-response timeouts. Sits between the debounced push-button pulses and the bin2bcd/display path.

Parameters:
MS_DIV, 50000, clocks per 1 ms tick (50 MHz clk)
MIN_WAIT_MS, 2000, fixed part of the pre-LED wait, in ms
WAIT_RAND_BITS, 12, width of the random wait addend (0..2^WAIT_RAND_BITS-1 ms)
TIMEOUT_MS, 1000, maximum measured reaction time, in ms
BIN_W, 14, width of bin output; must hold TIMEOUT_MS (max 9999)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous reset, active-low
start  in  1  one-cycle pulse, synchronous and debounced
stop  in  1  one-cycle pulse, synchronous and debounced
clear  in  1  one-cycle pulse, synchronous and debounced
led  out  1  stimulus LED; high only in MEASURE
bin  out  BIN_W  latched reaction time in ms, to the converter
conv_start  out  1  one-cycle request to the converter
conv_done  in  1  one-cycle done_tick from the converter
result_valid  out  1  converter BCD output holds the current trial
cheat  out  1  stop was pressed before the LED came on
timeout  out  1  no stop within TIMEOUT_MS
state  out  3  current FSM state, for debug

Behaviour:
- Async reset (reset=0): state=IDLE; all outputs 0; bin=0; counters 0; LFSR=16'hACE1.
- Prescaler: counts 0..MS_DIV-1. ms_tick is high in the cycle the count equals MS_DIV-1. The prescaler clears on every entry to WAIT and MEASURE, so the first ms is always full length.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11. Advances every clock in all states.
- Input priority, same cycle: clear > stop > start.
- State encodings: IDLE=0, WAIT=1, MEASURE=2, CONVERT=3, SHOW=4, CHEAT=5. All other codes go to IDLE.
- IDLE: on start, latch wait_target = MIN_WAIT_MS + lfsr[WAIT_RAND_BITS-1:0], clear wait_cnt and the flags, go to WAIT.
- WAIT: wait_cnt increments on each ms_tick.
  - stop: go to CHEAT, cheat=1.
  - ms_tick with wait_cnt == wait_target-1: go to MEASURE, ms_cnt=0, led=1 from the next cycle.
  - start is ignored.
- MEASURE: led=1; ms_cnt increments on each ms_tick.
  - stop: bin=ms_cnt as it stands before any same-cycle increment, then go to CONVERT.
  - ms_tick with ms_cnt == TIMEOUT_MS-1: bin=TIMEOUT_MS, timeout=1, go to CONVERT.
  - stop in the same cycle as the timeout tick: stop wins, timeout stays 0.
  - start is ignored.
- CONVERT: conv_start is registered and high for exactly the first cycle in the state; led=0.
  - conv_done: result_valid=1, go to SHOW.
  - conv_done arriving in the same cycle as conv_start is accepted.
- SHOW: result_valid, bin and timeout hold.
  - start: new trial, same as the IDLE start action; result_valid=0.
  - clear: go to IDLE.
- CHEAT: cheat holds until clear, then go to IDLE. start and stop are ignored.
- clear in any state: go to IDLE next cycle; led, result_valid, cheat, timeout, conv_start = 0; bin holds.
- conv_done outside CONVERT is ignored. This covers a converter that is still running after a clear.
- All outputs are registered. Counter widths are $clog2 of their maxima. Addition is unsigned; no wrap is reachable.

Optional Feature:
BEST_TIME_EN
- When defined: adds output best_ms[BIN_W-1:0], reset value all-ones. On each SHOW entry with timeout=0, best_ms = min(best_ms, bin). Cheat and timeout trials never update it, and clear does not reset it.
- When undefined: no port and no register; behaviour is otherwise identical.

Decomposition:
- Package reaction_pkg holds:
  - the state encoding localparams;
  - the LFSR seed and tap constant;
  - the default MS_DIV / TIMEOUT_MS values, shared with the stopwatch and bin2bcd blocks.
- One natural sub-module: ms_tick_gen (prescaler with sync clear and tick output), reusable by the stopwatch.

Test Plan:
Bench uses MS_DIV=4, MIN_WAIT_MS=3, WAIT_RAND_BITS=2, TIMEOUT_MS=10.
- Normal trial: start, then stop 5 ms after the led rises. Expect bin=5, one conv_start pulse, result_valid after conv_done, led=0.
- Cheat: start, then stop 1 ms later. Expect cheat=1, led never high, conv_start never pulses; clear returns to IDLE with cheat=0.
- Timeout: start with no stop. Expect bin=10, timeout=1, led high for exactly 40 clocks.
- Simultaneous stop and timeout tick: expect bin=9, timeout=0.
- Clear mid-CONVERT, then a late conv_done: expect state=IDLE and result_valid stays 0. Separately, async reset during MEASURE clears all outputs immediately.
- BEST_TIME_EN: trials of 7, 4, then a timeout. Expect best_ms sequence 16383 → 7 → 4 → 4.
